instr_fetch_cache: RTL
======================

Name: instr_fetch_cache

Overview:
- Upstream of the core's instruction port; sole source of the core's 64-bit instruction doubleword input.
- Direct-mapped doubleword cache in front of a 32-bit external memory bus with req/ack handshake.
- Hits return data the next cycle. Misses fetch two 32-bit beats, raise OUT_stall, and return data once filled.
- Top level ties the core's enable to !OUT_stall.

Parameters:
LINES, 64, number of cache entries (one 64-bit doubleword each), power of two, >=2
IDX_W, $clog2(LINES), index width (derived, not overridden)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, asynchronous, active-low
IN_readEnable_n  in  1  active-low fetch request (core's instruction read enable)
IN_addr  in  29  doubleword address
OUT_instrRaw  out  64  fetched doubleword; bits [31:0] = lower word
OUT_stall  out  1  fetch unit busy; requests ignored while high
IN_invalidate  in  1  clear all valid bits (fence.i)
OUT_EXT_req  out  1  external read request
OUT_EXT_addr  out  30  external word address
IN_EXT_ack  in  1  beat accepted; data valid this cycle
IN_EXT_data  in  32  external read data

Behaviour:
- Reset (rst=0, async): all valid bits 0, FSM=IDLE, OUT_stall=0, OUT_EXT_req=0, OUT_EXT_addr=0, OUT_instrRaw=0. Reset mid-fill aborts the fill; no line is written.
- Address split: index=IN_addr[IDX_W-1:0]; tag=IN_addr[28:IDX_W].
- Request accepted when IN_readEnable_n=0 and FSM is IDLE or RESP. Otherwise ignored (core re-presents).
- Hit (cycle N: valid && tag match && !IN_invalidate):
  - OUT_instrRaw = line data, registered in N+1.
  - OUT_stall stays 0.
  - FSM stays IDLE.
- Miss (cycle N): latch address and go to FETCH_LO in N+1.
  - OUT_stall=1 from N+1.
  - OUT_instrRaw holds its previous value until RESP.
- FETCH_LO: OUT_EXT_req=1, OUT_EXT_addr={addr,1'b0}, both held stable until IN_EXT_ack=1. Capture IN_EXT_data as lower word, then go to FETCH_HI.
- FETCH_HI: OUT_EXT_req=1, OUT_EXT_addr={addr,1'b1}. On ack, capture the upper word and go to RESP.
- RESP (exactly one cycle):
  - OUT_instrRaw={hi,lo}; OUT_stall=0.
  - Line written with valid=1, unless an invalidate was seen during the fill.
  - A new request in RESP is handled as in IDLE; RESP's lookup sees the just-written line. Next state is IDLE, or FETCH_LO on a new miss.
- Minimum miss latency: ack on the first cycle of each beat gives OUT_stall high for 2 cycles and data in N+3.
- IN_invalidate:
  - Clears all valid bits in the cycle it is sampled.
  - A same-cycle lookup is treated as a miss.
  - During FETCH_LO/FETCH_HI it sets a sticky flag: the in-flight fill still returns data but does not mark the line valid. Flag clears on RESP.
- Conflicting index: fill overwrites the old tag and data (no replacement choice).
- OUT_EXT_req is never asserted in IDLE or RESP. Ack is ignored when req=0.

Optional Feature:
- Macro IFC_STATS_EN.
- Defined: adds output ports OUT_hitCount[31:0] and OUT_missCount[31:0].
  - Incremented on each accepted hit or miss; wrap 0xFFFFFFFF→0; reset to 0.
  - Invalidate-forced misses count as misses.
- Undefined: ports and counters absent; all other behaviour identical.

Decomposition:
- Shared package:
  - enum IFC_State {IDLE, FETCH_LO, FETCH_HI, RESP}.
  - struct IFC_Line {valid, tag[28-IDX_W:0], data[63:0]}.
  - Constant IFC_BEATS=2.
- One sub-module: ifc_line_ram, the valid/tag/data array.
  - Asynchronous read port, single synchronous write port, global valid-clear input.
  - Flop-based, so it can later swap to SRAM without touching the FSM.

Test Plan:
- Cold miss: reset, request addr 0x0000010, ack each beat after 2 cycles. Expect:
  - OUT_EXT_addr 0x0000020 then 0x0000021.
  - OUT_stall high 6 cycles.
  - OUT_instrRaw={0xBBBBBBBB,0xAAAAAAAA} when the beats return 0xAAAAAAAA then 0xBBBBBBBB.
- Warm hit: re-request 0x0000010 the cycle after RESP → data next cycle, OUT_stall never rises, OUT_EXT_req stays 0.
- Conflict: with LINES=64, fill 0x0000010, then request 0x0000050 (same index) → miss and refill; request 0x0000010 again → miss.
- Invalidate mid-fill: assert IN_invalidate during FETCH_HI → data still returned in RESP; immediate re-request of the same address misses.
- Reset mid-fill: drop rst during FETCH_LO, release, request the same address → OUT_EXT_req=0 and OUT_stall=0 immediately after reset; new request misses.
- Stats (IFC_STATS_EN): 3 misses + 5 hits → OUT_missCount=3, OUT_hitCount=5; preload near wrap to check 0xFFFFFFFF→0.

Source files
------------

// File: rtl/instr_fetch_cache_pkg.sv
// instr_fetch_cache_pkg: shared types and constants for the instruction fetch cache.
package instr_fetch_cache_pkg;
  localparam int IFC_LINES = 64;
  localparam int IFC_IDX_W = $clog2(IFC_LINES);
  localparam int IFC_BEATS = 2;
  typedef enum logic [1:0] {IDLE, FETCH_LO, FETCH_HI, RESP} IFC_State;
  typedef struct packed {
    logic                   valid;
    logic [28-IFC_IDX_W:0]  tag;
    logic [63:0]            data;
  } IFC_Line;
endpackage

// File: rtl/instr_fetch_cache_line_ram.sv
// ifc_line_ram: flop-based valid/tag/data array, async read, one sync write, global valid clear.
module ifc_line_ram
  import instr_fetch_cache_pkg::*;
#(
  parameter int LINES = IFC_LINES,
  localparam int IDX_W = $clog2(LINES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  IFC_Line          wline,
  input  logic [IDX_W-1:0] raddr,
  output IFC_Line          rline
);
  IFC_Line mem_q [LINES];
  IFC_Line mem_d [LINES];
  always_comb begin
    for (int i = 0; i < LINES; i++) begin
      mem_d[i] = mem_q[i];
      if (we && waddr == IDX_W'(i)) mem_d[i] = wline;
      if (clr) mem_d[i].valid = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < LINES; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end
  // write-through bypass so a lookup in the write cycle sees the new line
  assign rline = (we && waddr == raddr) ? wline : mem_q[raddr];
endmodule

// File: rtl/instr_fetch_cache.sv
// instr_fetch_cache: direct-mapped doubleword I-cache over a 32-bit req/ack bus.
// Optional hit/miss counters when IFC_STATS_EN is defined.
module instr_fetch_cache
  import instr_fetch_cache_pkg::*;
#(
  parameter int LINES = IFC_LINES,
  localparam int IDX_W = $clog2(LINES)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        IN_readEnable_n,
  input  logic [28:0] IN_addr,
  output logic [63:0] OUT_instrRaw,
  output logic        OUT_stall,
  input  logic        IN_invalidate,
  output logic        OUT_EXT_req,
  output logic [29:0] OUT_EXT_addr,
  input  logic        IN_EXT_ack,
  input  logic [31:0] IN_EXT_data
`ifdef IFC_STATS_EN
  ,
  output logic [31:0] OUT_hitCount,
  output logic [31:0] OUT_missCount
`endif
);
  IFC_State    state_q, state_d;
  logic [28:0] addr_q, addr_d;
  logic [31:0] lo_q, lo_d;
  logic [63:0] instr_q, instr_d;
  logic        inv_q, inv_d;
  logic        fetch, accept, hit, miss, we;
  IFC_Line     rline, wline;

  ifc_line_ram #(.LINES(LINES)) u_ram (
    .clk   (clk),
    .rst   (rst),
    .clr   (IN_invalidate),
    .we    (we),
    .waddr (addr_q[IDX_W-1:0]),
    .wline (wline),
    .raddr (IN_addr[IDX_W-1:0]),
    .rline (rline)
  );

  always_comb begin
    fetch   = state_q == FETCH_LO || state_q == FETCH_HI;
    accept  = !IN_readEnable_n && !fetch;
    hit     = accept && rline.valid && rline.tag == IN_addr[28:IDX_W] && !IN_invalidate;
    miss    = accept && !hit;
    we      = state_q == RESP;
    wline   = '{valid: !inv_q && !IN_invalidate, tag: addr_q[28:IDX_W], data: instr_q};
    state_d = state_q == FETCH_LO ? (IN_EXT_ack ? FETCH_HI : FETCH_LO) :
              state_q == FETCH_HI ? (IN_EXT_ack ? RESP : FETCH_HI) :
              miss ? FETCH_LO : IDLE;
    addr_d  = miss ? IN_addr : addr_q;
    lo_d    = (state_q == FETCH_LO && IN_EXT_ack) ? IN_EXT_data : lo_q;
    instr_d = hit ? rline.data :
              (state_q == FETCH_HI && IN_EXT_ack) ? {IN_EXT_data, lo_q} : instr_q;
    // an invalidate seen mid-fill must keep the returning line from becoming valid
    inv_d   = fetch && (inv_q || IN_invalidate);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      lo_q    <= '0;
      instr_q <= '0;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      lo_q    <= lo_d;
      instr_q <= instr_d;
      inv_q   <= inv_d;
    end
  end

  assign OUT_instrRaw = instr_q;
  assign OUT_stall    = fetch;
  assign OUT_EXT_req  = fetch;
  assign OUT_EXT_addr = fetch ? {addr_q, state_q == FETCH_HI} : '0;

`ifdef IFC_STATS_EN
  logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;
  always_comb begin
    hit_cnt_d  = hit_cnt_q + 32'(hit);
    miss_cnt_d = miss_cnt_q + 32'(miss);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end
  assign OUT_hitCount  = hit_cnt_q;
  assign OUT_missCount = miss_cnt_q;
`endif
endmodule
